// File: rtl/conv_mem_responder_if.sv
// ----------------------------------------------------------------------------
// conv_mem_responder_if
//   Accelerator-facing bus of the convolution memory responder.
//   Carries the start handshake (ready/busy), the image read port, the
//   layer write port and the layer read port.
//
//   Signals:
//     ready     responder -> accelerator   one-cycle start pulse
//     busy      accelerator -> responder   accelerator is working
//     iaddr     accelerator -> responder   image read address
//     idata     responder -> accelerator   image read data (1-cycle latency)
//     cwr       accelerator -> responder   layer write enable
//     caddr_wr  accelerator -> responder   layer write address
//     cdata_wr  accelerator -> responder   layer write data
//     crd       accelerator -> responder   layer read enable
//     caddr_rd  accelerator -> responder   layer read address
//     cdata_rd  responder -> accelerator   layer read data (1-cycle latency)
//     csel      accelerator -> responder   layer select (001 = L0, 011 = L1)
//
//   Modports:
//     slave   the memory responder
//     master  the accelerator (or a bench standing in for it)
// ----------------------------------------------------------------------------
interface conv_mem_responder_if #(
    parameter int DW = 20,
    parameter int AW = 12
);
    logic          ready;
    logic          busy;
    logic [AW-1:0] iaddr;
    logic [DW-1:0] idata;
    logic          cwr;
    logic [AW-1:0] caddr_wr;
    logic [DW-1:0] cdata_wr;
    logic          crd;
    logic [AW-1:0] caddr_rd;
    logic [DW-1:0] cdata_rd;
    logic [2:0]    csel;

    modport slave (
        output ready, idata, cdata_rd,
        input  busy, iaddr, cwr, caddr_wr, cdata_wr, crd, caddr_rd, csel
    );

    modport master (
        input  ready, idata, cdata_rd,
        output busy, iaddr, cwr, caddr_wr, cdata_wr, crd, caddr_rd, csel
    );
endinterface

// File: rtl/conv_mem_responder.sv
// ----------------------------------------------------------------------------
// conv_mem_responder
//   Memory-side responder for the convolution accelerator. Holds the 64x64
//   input image ROM, the layer-0 memory (4096 words) and the layer-1 memory
//   (1024 words). Launches the accelerator with a one-cycle ready pulse,
//   watches busy to detect completion, and serves the accelerator's image
//   read, layer write and layer read ports. The host side gets an image load
//   port and a dump port for reading back the layer memories.
//
//   Ports:
//     clk, reset      clock, asynchronous active-high reset
//     start           host request to launch the accelerator
//     ld_valid/addr/data  image load (accepted only in IDLE or DONE)
//     acc             accelerator bus (slave side)
//     dump_sel/addr   dump memory select and address
//     dump_data       dump read data (1-cycle latency)
//     done            run complete, held until the next start
//     err             sticky flags: [0] busy timeout, [1] bad layer select or
//                     L1 address out of range, [2] layer write outside RUN,
//                     [3] image load while running
//     wr_cnt_l0/l1    accepted layer writes, saturating
// ----------------------------------------------------------------------------
module conv_mem_responder #(
    parameter int DW           = 20,
    parameter int AW           = 12,
    parameter int L1_AW        = 10,
    parameter int BUSY_TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             ld_valid,
    input  logic [AW-1:0]    ld_addr,
    input  logic [DW-1:0]    ld_data,
    conv_mem_responder_if.slave acc,
    input  logic [2:0]       dump_sel,
    input  logic [AW-1:0]    dump_addr,
    output logic [DW-1:0]    dump_data,
    output logic             done,
    output logic [3:0]       err,
    output logic [AW:0]      wr_cnt_l0,
    output logic [L1_AW:0]   wr_cnt_l1
);

    localparam logic [2:0] SEL_L0 = 3'b001;
    localparam logic [2:0] SEL_L1 = 3'b011;

    localparam int               TMO_W    = $clog2(BUSY_TIMEOUT + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(BUSY_TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        WAIT_BUSY,
        RUN,
        DONE
    } state_t;

    // Memories: no reset, contents survive a reset.
    logic [DW-1:0] img_mem [2**AW];
    logic [DW-1:0] l0_mem  [2**AW];
    logic [DW-1:0] l1_mem  [2**L1_AW];

    state_t           state_q,     state_d;
    logic [TMO_W-1:0] tmo_cnt_q,   tmo_cnt_d;
    logic             busy_prev_q;
    logic             done_q,      done_d;
    logic [3:0]       err_q,       err_d;
    logic [AW:0]      cnt_l0_q,    cnt_l0_d;
    logic [L1_AW:0]   cnt_l1_q,    cnt_l1_d;
    logic [DW-1:0]    idata_q,     idata_d;
    logic [DW-1:0]    cdata_rd_q,  cdata_rd_d;
    logic [DW-1:0]    dump_data_q, dump_data_d;

    logic start_acc;
    logic tmo_hit;
    logic img_we;
    logic l0_we;
    logic l1_we;

    // ------------------------------------------------------------------
    // Next-state, flags, counters and read data
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        tmo_cnt_d = tmo_cnt_q;
        start_acc = 1'b0;
        tmo_hit   = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = ARM;
                    start_acc = 1'b1;
                end
            end
            ARM: begin
                state_d   = WAIT_BUSY;
                tmo_cnt_d = '0;
            end
            WAIT_BUSY: begin
                // busy wins over a timeout landing on the same cycle
                if (acc.busy) begin
                    state_d = RUN;
                end else if (tmo_cnt_q == TMO_LAST) begin
                    state_d = DONE;
                    tmo_hit = 1'b1;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                end
            end
            RUN: begin
                // completion is the falling edge of busy
                if (busy_prev_q && !acc.busy) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    state_d   = ARM;
                    start_acc = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        img_we = ld_valid && (state_q == IDLE || state_q == DONE);
        l0_we  = acc.cwr && (acc.csel == SEL_L0);
        l1_we  = acc.cwr && (acc.csel == SEL_L1) &&
                 (acc.caddr_wr[AW-1:L1_AW] == '0);

        // A start clears the run statistics first; events in the same
        // cycle are then accounted against the new run.
        err_d    = start_acc ? 4'b0000 : err_q;
        cnt_l0_d = start_acc ? '0 : cnt_l0_q;
        cnt_l1_d = start_acc ? '0 : cnt_l1_q;

        if (tmo_hit)                           err_d[0] = 1'b1;
        if (acc.cwr && !l0_we && !l1_we)       err_d[1] = 1'b1;
        if (acc.cwr && state_q != RUN)         err_d[2] = 1'b1;
        if (ld_valid && !img_we)               err_d[3] = 1'b1;

        if (l0_we && cnt_l0_d != '1) cnt_l0_d = cnt_l0_d + 1'b1;
        if (l1_we && cnt_l1_d != '1) cnt_l1_d = cnt_l1_d + 1'b1;

        done_d = (state_d == DONE);

        idata_d = img_mem[acc.iaddr];

        cdata_rd_d = cdata_rd_q;
        if (acc.crd) begin
            case (acc.csel)
                SEL_L0:  cdata_rd_d = l0_mem[acc.caddr_rd];
                SEL_L1:  cdata_rd_d = l1_mem[acc.caddr_rd[L1_AW-1:0]];
                default: cdata_rd_d = '0;
            endcase
        end

        case (dump_sel)
            SEL_L0:  dump_data_d = l0_mem[dump_addr];
            SEL_L1:  dump_data_d = l1_mem[dump_addr[L1_AW-1:0]];
            default: dump_data_d = '0;
        endcase
    end

    // ------------------------------------------------------------------
    // Control and read-data registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            tmo_cnt_q   <= '0;
            busy_prev_q <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= '0;
            cnt_l0_q    <= '0;
            cnt_l1_q    <= '0;
            idata_q     <= '0;
            cdata_rd_q  <= '0;
            dump_data_q <= '0;
        end else begin
            state_q     <= state_d;
            tmo_cnt_q   <= tmo_cnt_d;
            busy_prev_q <= acc.busy;
            done_q      <= done_d;
            err_q       <= err_d;
            cnt_l0_q    <= cnt_l0_d;
            cnt_l1_q    <= cnt_l1_d;
            idata_q     <= idata_d;
            cdata_rd_q  <= cdata_rd_d;
            dump_data_q <= dump_data_d;
        end
    end

    // ------------------------------------------------------------------
    // Memory writes. Reads above sample the pre-write contents, so a
    // same-cycle read and write to one address returns the old word.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (img_we) img_mem[ld_addr] <= ld_data;
    end

    always_ff @(posedge clk) begin
        if (l0_we) l0_mem[acc.caddr_wr] <= acc.cdata_wr;
    end

    always_ff @(posedge clk) begin
        if (l1_we) l1_mem[acc.caddr_wr[L1_AW-1:0]] <= acc.cdata_wr;
    end

    // Ready is decoded from the registered state so an asynchronous reset
    // drops it immediately.
    assign acc.ready    = (state_q == ARM);
    assign acc.idata    = idata_q;
    assign acc.cdata_rd = cdata_rd_q;
    assign dump_data    = dump_data_q;
    assign done         = done_q;
    assign err          = err_q;
    assign wr_cnt_l0    = cnt_l0_q;
    assign wr_cnt_l1    = cnt_l1_q;

endmodule

// File: tb/tb_conv_mem_responder.sv
// ----------------------------------------------------------------------------
// tb_conv_mem_responder
//   Directed bench for conv_mem_responder: image load and read-back, launch
//   handshake, layer writes/reads, error flags, read-before-write, busy
//   timeout, restart clearing and reset mid-run.
// ----------------------------------------------------------------------------
module tb_conv_mem_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        ld_valid;
    logic [11:0] ld_addr;
    logic [19:0] ld_data;
    logic [2:0]  dump_sel;
    logic [11:0] dump_addr;
    logic [19:0] dump_data;
    logic        done;
    logic [3:0]  err;
    logic [12:0] wr_cnt_l0;
    logic [10:0] wr_cnt_l1;

    conv_mem_responder_if acc_if ();

    conv_mem_responder dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .ld_valid  (ld_valid),
        .ld_addr   (ld_addr),
        .ld_data   (ld_data),
        .acc       (acc_if),
        .dump_sel  (dump_sel),
        .dump_addr (dump_addr),
        .dump_data (dump_data),
        .done      (done),
        .err       (err),
        .wr_cnt_l0 (wr_cnt_l0),
        .wr_cnt_l1 (wr_cnt_l1)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    // Advance one clock; inputs are changed and outputs sampled 1ns later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic layer_write(input logic [2:0] sel, input logic [11:0] addr, input logic [19:0] data);
        acc_if.cwr      = 1'b1;
        acc_if.csel     = sel;
        acc_if.caddr_wr = addr;
        acc_if.cdata_wr = data;
        step();
        acc_if.cwr      = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int k;
        reset           = 1'b1;
        start           = 1'b0;
        ld_valid        = 1'b0;
        ld_addr         = '0;
        ld_data         = '0;
        dump_sel        = 3'b000;
        dump_addr       = '0;
        acc_if.busy     = 1'b0;
        acc_if.iaddr    = '0;
        acc_if.cwr      = 1'b0;
        acc_if.caddr_wr = '0;
        acc_if.cdata_wr = '0;
        acc_if.crd      = 1'b0;
        acc_if.caddr_rd = '0;
        acc_if.csel     = 3'b000;

        step();
        step();
        check("rst_ready", 32'(acc_if.ready), 32'h0);
        check("rst_done",  32'(done),         32'h0);
        check("rst_err",   32'(err),          32'h0);
        check("rst_cnt0",  32'(wr_cnt_l0),    32'h0);
        check("rst_idata", 32'(acc_if.idata), 32'h0);
        reset = 1'b0;
        step();

        // Image load: img[a] = a
        for (int a = 0; a < 4096; a++) begin
            ld_valid = 1'b1;
            ld_addr  = 12'(a);
            ld_data  = 20'(a);
            step();
        end
        ld_valid = 1'b0;
        check("load_in_idle_err", 32'(err), 32'h0);

        // Image read, single then back-to-back sweep
        acc_if.iaddr = 12'h041;
        step();
        check("idata_041", 32'(acc_if.idata), 32'h00041);
        for (int i = 0; i < 4096; i++) begin
            acc_if.iaddr = 12'(i);
            step();
            if (i % 512 == 7 || i == 4095)
                check($sformatf("idata_sweep_%0d", i), 32'(acc_if.idata), 32'(i));
        end

        // Launch: ready for exactly one cycle, busy two cycles later
        start = 1'b1;
        step();
        start = 1'b0;
        check("ready_pulse", 32'(acc_if.ready), 32'h1);
        step();
        check("ready_low", 32'(acc_if.ready), 32'h0);
        step();
        acc_if.busy = 1'b1;
        step();
        check("run_done", 32'(done), 32'h0);
        check("run_err",  32'(err),  32'h0);

        // L0 write / read at the top address
        layer_write(3'b001, 12'hFFF, 20'h12345);
        check("cnt_l0_1", 32'(wr_cnt_l0), 32'h1);
        acc_if.crd      = 1'b1;
        acc_if.csel     = 3'b001;
        acc_if.caddr_rd = 12'hFFF;
        step();
        acc_if.crd      = 1'b0;
        acc_if.caddr_rd = 12'h000;
        check("rd_l0_fff", 32'(acc_if.cdata_rd), 32'h12345);
        step();
        check("rd_hold", 32'(acc_if.cdata_rd), 32'h12345);

        // L1 write and dump
        layer_write(3'b011, 12'h3FF, 20'h12345);
        check("cnt_l1_1", 32'(wr_cnt_l1), 32'h1);
        dump_sel  = 3'b011;
        dump_addr = 12'h3FF;
        step();
        check("dump_l1_3ff", 32'(dump_data), 32'h12345);
        dump_sel  = 3'b001;
        dump_addr = 12'hFFF;
        step();
        check("dump_l0_fff", 32'(dump_data), 32'h12345);
        dump_sel  = 3'b010;
        step();
        check("dump_bad_sel", 32'(dump_data), 32'h0);

        // Bad L1 address and bad select
        layer_write(3'b011, 12'h000, 20'h00777);
        check("cnt_l1_2", 32'(wr_cnt_l1), 32'h2);
        check("err_clean", 32'(err), 32'h0);
        layer_write(3'b011, 12'h400, 20'h0BAD0);
        check("err_l1_range", 32'(err), 32'h2);
        check("cnt_l1_hold", 32'(wr_cnt_l1), 32'h2);
        dump_sel  = 3'b011;
        dump_addr = 12'h000;
        step();
        check("l1_0_unchanged", 32'(dump_data), 32'h00777);
        layer_write(3'b010, 12'h000, 20'h0BAD1);
        check("err_bad_sel", 32'(err), 32'h2);
        check("cnt_l0_hold", 32'(wr_cnt_l0), 32'h1);
        check("cnt_l1_hold2", 32'(wr_cnt_l1), 32'h2);

        // Read-before-write on L0[0x010]
        layer_write(3'b001, 12'h010, 20'h00005);
        acc_if.cwr      = 1'b1;
        acc_if.csel     = 3'b001;
        acc_if.caddr_wr = 12'h010;
        acc_if.cdata_wr = 20'h0000A;
        acc_if.crd      = 1'b1;
        acc_if.caddr_rd = 12'h010;
        step();
        acc_if.cwr = 1'b0;
        check("rbw_old", 32'(acc_if.cdata_rd), 32'h00005);
        step();
        acc_if.crd = 1'b0;
        check("rbw_new", 32'(acc_if.cdata_rd), 32'h0000A);
        check("cnt_l0_3", 32'(wr_cnt_l0), 32'h3);

        // Image load while running is dropped
        ld_valid = 1'b1;
        ld_addr  = 12'h000;
        ld_data  = 20'hFFFFF;
        step();
        ld_valid = 1'b0;
        check("err_load_run", 32'(err), 32'hA);
        acc_if.iaddr = 12'h000;
        step();
        check("img0_kept", 32'(acc_if.idata), 32'h0);

        // Completion on busy falling edge
        acc_if.busy = 1'b0;
        step();
        check("done_after_busy", 32'(done), 32'h1);

        // Write outside RUN still lands, flags err[2]
        layer_write(3'b001, 12'h020, 20'h00033);
        check("err_wr_outside", 32'(err), 32'hE);
        check("cnt_l0_4", 32'(wr_cnt_l0), 32'h4);
        dump_sel  = 3'b001;
        dump_addr = 12'h020;
        step();
        check("dump_l0_020", 32'(dump_data), 32'h00033);

        // Load accepted in DONE
        ld_valid = 1'b1;
        ld_addr  = 12'h005;
        ld_data  = 20'hABCDE;
        step();
        ld_valid     = 1'b0;
        acc_if.iaddr = 12'h005;
        step();
        check("img5_loaded", 32'(acc_if.idata), 32'hABCDE);
        check("err_load_done", 32'(err), 32'hE);

        // Restart clears statistics; then let busy time out
        start = 1'b1;
        step();
        start = 1'b0;
        check("restart_ready", 32'(acc_if.ready), 32'h1);
        check("restart_err",   32'(err),          32'h0);
        check("restart_cnt0",  32'(wr_cnt_l0),    32'h0);
        check("restart_cnt1",  32'(wr_cnt_l1),    32'h0);
        check("restart_done",  32'(done),         32'h0);
        k = 0;
        for (int c = 1; c <= 40; c++) begin
            step();
            if (done) begin
                k = c;
                break;
            end
        end
        check("timeout_latency", 32'(k), 32'd17);
        check("timeout_err", 32'(err), 32'h1);

        // Reset mid-launch: ready drops at once, memories survive
        start = 1'b1;
        step();
        start = 1'b0;
        check("arm_ready", 32'(acc_if.ready), 32'h1);
        reset = 1'b1;
        #1;
        check("reset_ready_drop", 32'(acc_if.ready), 32'h0);
        check("reset_err", 32'(err), 32'h0);
        step();
        reset = 1'b0;
        dump_sel  = 3'b001;
        dump_addr = 12'h020;
        step();
        check("mem_retained", 32'(dump_data), 32'h00033);
        check("reset_done", 32'(done), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/conv_mem_responder.md
Name: conv_mem_responder

Overview:
- Memory-side responder for the convolution accelerator.
- Holds the 64x64 input image ROM, the layer-0 memory (4096x20) and the layer-1 memory (1024x20).
- Drives the ready start pulse and answers the accelerator's image-read, layer-write and layer-read ports.
- Tracks busy to detect completion. Gives the host/bench a load port for the image and a dump port for the layer memories.

Parameters:
- DW, 20, data width of all memories
- AW, 12, address width (4096 image/L0 words)
- L1_AW, 10, layer-1 address width (1024 words)
- BUSY_TIMEOUT, 16, max cycles from ready pulse to busy=1 before flagging an error

Ports:
- clk  in  1  clock
- reset  in  1  async active-high reset
- start  in  1  host request to launch the accelerator
- ld_valid  in  1  image load strobe
- ld_addr  in  12  image load address
- ld_data  in  20  image load data
- ready  out  1  start pulse to accelerator
- busy  in  1  accelerator busy
- iaddr  in  12  image read address
- idata  out  20  image read data
- cwr  in  1  layer write enable
- caddr_wr  in  12  layer write address
- cdata_wr  in  20  layer write data
- crd  in  1  layer read enable
- caddr_rd  in  12  layer read address
- cdata_rd  out  20  layer read data
- csel  in  3  layer select: 3'b001 = L0, 3'b011 = L1
- dump_sel  in  3  dump memory select (same encoding as csel)
- dump_addr  in  12  dump address
- dump_data  out  20  dump read data
- done  out  1  accelerator run complete
- err  out  4  sticky error flags
- wr_cnt_l0  out  13  accepted L0 writes
- wr_cnt_l1  out  11  accepted L1 writes

Behaviour:
- Reset: reset is asynchronous, active-high; clock is clk. All outputs go to 0. State = IDLE. Memory contents are not cleared.
- FSM states: IDLE, ARM, WAIT_BUSY, RUN, DONE.
  - IDLE: start=1 -> ARM.
  - ARM: ready=1 for exactly this one cycle -> WAIT_BUSY.
  - WAIT_BUSY:
    - busy=1 -> RUN.
    - A cycle counter starts at ARM exit. If it reaches BUSY_TIMEOUT with busy still 0: set err[0], go to DONE.
  - RUN: busy 1->0 (registered previous value = 1, current = 0) -> DONE.
  - DONE: done=1, held. start=1 -> ARM.
- On every start acceptance (IDLE or DONE): err, wr_cnt_l0, wr_cnt_l1 and done clear to 0 on that edge.
- Image load:
  - ld_valid accepted only in IDLE or DONE: img[ld_addr] <= ld_data.
  - ld_valid in any other state is ignored and sets err[3].
- Image read: idata <= img[iaddr] every cycle, in all states. One-cycle registered latency: value for the iaddr sampled at edge N is visible after edge N.
- Layer write (cwr=1, evaluated in any state):
  - csel=001: L0[caddr_wr] <= cdata_wr; wr_cnt_l0 increments.
  - csel=011 and caddr_wr[11:10]==0: L1[caddr_wr[9:0]] <= cdata_wr; wr_cnt_l1 increments.
  - csel=011 and caddr_wr[11:10]!=0: write suppressed; set err[1].
  - Any other csel: write suppressed; set err[1].
  - cwr in a state other than RUN: write still performed; set err[2].
- Both write counters saturate at all-ones.
- Layer read:
  - crd=1: cdata_rd <= selected memory at caddr_rd, one-cycle latency. L1 uses caddr_rd[9:0].
  - Invalid csel returns 0.
  - crd=0: cdata_rd holds its value.
- Simultaneous write and read to the same memory and address: read returns the old data (read-before-write).
- Dump port: dump_data <= selected memory at dump_addr every cycle, one-cycle latency. Invalid dump_sel returns 0. Fully independent of the accelerator ports.
- start while in ARM, WAIT_BUSY or RUN: ignored.
- Reset mid-run: FSM returns to IDLE and ready drops immediately. Memories retain their contents.

Test Plan:
- Load img[0..4095] = address value, then pulse start -> ready high for exactly 1 cycle; busy raised 2 cycles later -> state RUN, done=0, err=0.
- Drive iaddr=0x041 -> idata=0x00041 on the following cycle. Step iaddr 0..4095 back-to-back -> idata tracks with exactly 1-cycle lag.
- In RUN: cwr, csel=001, caddr_wr=0x0FFF, data 0x12345 -> wr_cnt_l0=1. Then crd, caddr_rd=0x0FFF -> cdata_rd=0x12345 next cycle. Same write with csel=011 at 0x3FF; dump_sel=011, dump_addr=0x3FF -> dump_data=0x12345.
- In RUN: cwr with csel=011, caddr_wr=0x400 -> L1[0] unchanged, err[1]=1. cwr with csel=010 -> err[1] stays set, nothing written.
- Same-cycle cwr and crd to L0 address 0x010 (old 0x00005, new 0x0000A) -> cdata_rd=0x00005. A subsequent read returns 0x0000A.
- After start, busy held 0 for 16 cycles -> err[0]=1, done=1. busy 1->0 in a normal run -> done=1 next cycle. New start -> err and counters cleared, ready pulses again.
